flash_phy_host: RTL and testbench
=================================

Name: flash_phy_host

Overview:
- Initiator side of the emulated flash macro command interface; sits between the flash controller datapath and the flash macro.
- Accepts read, program, page-erase and bank-erase requests over a valid/ready host port.
- Drives the macro's single-cycle command strobes and tracks up to MaxRdOut pipelined reads.
- Returns in-order responses through a small response FIFO, with per-operation timeout and sticky error reporting.

Parameters:
- PagesPerBank, 256, data pages per bank
- WordsPerPage, 256, words per page
- DataWidth, 32, bits per flash word
- MaxRdOut, 2, max reads in flight at the macro (equals macro input slice depth)
- TimeoutCycles, 200000, cycles without ack before an operation is declared timed out
- AddrW (local), $clog2(PagesPerBank)+$clog2(WordsPerPage), word address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high
- req_i  in  1  host request valid
- req_ready_o  out  1  request accepted when req_i&req_ready_o
- req_op_i  in  2  flash_phy_op_e
- req_addr_i  in  AddrW  word address (page base for page erase, ignored for bank erase)
- req_part_i  in  flash_part_e  data/info partition
- req_prog_type_i  in  flash_prog_e  program type
- req_wdata_i  in  DataWidth  program data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  host accepts response
- rsp_rdata_o  out  DataWidth  read data (0 for non-read ops)
- rsp_err_o  out  1  response carries error (timeout or unsupported prog type)
- err_o  out  1  sticky: spurious ack or timeout seen
- flash_rd_o, flash_prog_o, flash_pg_erase_o, flash_bk_erase_o  out  1 each  command strobes
- flash_prog_type_o  out  flash_prog_e  program type
- flash_addr_o  out  AddrW  command address
- flash_part_o  out  flash_part_e  command partition
- flash_prog_data_o  out  DataWidth  program data
- flash_ack_i  in  1  macro completion
- flash_rd_data_i  in  DataWidth  valid in the flash_ack_i cycle of a read
- flash_init_busy_i  in  1  macro initialising
- flash_prog_type_avail_i  in  ProgTypes  supported program types

Behaviour:
- Reset: all outputs 0; state StInit; rd_cnt=0; response FIFO empty; err_o cleared. The macro shares this reset domain.
- StInit: req_ready_o=0. Moves to StIdle on the first cycle flash_init_busy_i=0.
- Command outputs are registered; every strobe is high for exactly one cycle, in the cycle after acceptance.
- Read acceptance: state in {StIdle, StRead}, rd_cnt + fifo_occupancy < MaxRdOut. Back-to-back reads at one per cycle are allowed.
- rd_cnt counts reads issued and not yet acked. Issue and ack in the same cycle leave rd_cnt unchanged.
- Prog/erase acceptance: StIdle only, rd_cnt=0, FIFO empty. This guarantees the macro is idle on the strobe cycle. State then goes to StWait.
- Unsupported prog type (flash_prog_type_avail_i[type]=0): no strobe is issued. An error response is pushed the next cycle with rdata=0.
- Ack handling: each flash_ack_i pushes {flash_rd_data_i or 0, err=0} into the FIFO. rsp_valid_o rises the cycle after ack.
- An ack in StWait returns to StIdle. In StRead, StRead returns to StIdle when rd_cnt reaches 0.
- flash_ack_i with rd_cnt=0 outside StWait is ignored and sets err_o.
- Timeout: a counter clears on each issue or ack and counts while an op is outstanding. On reaching TimeoutCycles it pushes one error response, sets err_o and enters StError.
- StError: req_ready_o=0 and later acks are dropped; exit is by rst_i only.
- FIFO: depth MaxRdOut, registered output, no drop. Credit gating above makes overflow impossible.
- rsp_valid_o holds, with stable data, until rsp_ready_i.
- Responses are in request order.

Decomposition:
- Shared package flash_phy_pkg: flash_phy_op_e {OpRead=0, OpProg=1, OpPgErase=2, OpBkErase=3} and state enum {StInit, StIdle, StRead, StWait, StError}.
- flash_part_e, flash_prog_e and ProgTypes are reused from flash_ctrl_pkg.
- One sub-module: flash_phy_rsp_fifo (sync active-high reset, Depth=MaxRdOut, Width=DataWidth+1).

Test Plan:
- Init: hold flash_init_busy_i=1 for 10 cycles after reset -> req_ready_o=0 throughout; ready rises 1 cycle after busy falls.
- Read latency: erased word 0x010 read against the emulated macro -> flash_rd_o one cycle after accept; rsp_valid_o 4 cycles after accept; rdata=0xFFFF_FFFF; err=0.
- Program AND semantics: program 0x0000_FFFF then 0xFFFF_0000 to addr 0x020, then read -> rdata=0x0000_0000. Page erase page 0 and read -> 0xFFFF_FFFF.
- Pipelining/backpressure: 4 back-to-back reads with rsp_ready_i=0 -> only 2 strobes issued; ready stays low until the host pops; all 4 responses arrive in order.
- Timeout: TimeoutCycles=100, flash_ack_i forced 0 after a prog -> error response at cycle 100; err_o=1; StError; ready=0 until rst_i.
- Spurious ack and unsupported type: ack injected in StIdle -> err_o=1, no response. Repair type with avail bit=0 -> error response with no flash_prog_o pulse.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared flash controller types: partition select, program type and the
// number of program types the macro can advertise.
package flash_ctrl_pkg;

  typedef enum logic {
    FlashPartData = 1'b0,
    FlashPartInfo = 1'b1
  } flash_part_e;

  typedef enum logic {
    FlashProgNormal = 1'b0,
    FlashProgRepair = 1'b1
  } flash_prog_e;

  localparam int ProgTypes = 2;

endpackage

// File: rtl/flash_phy_pkg.sv
// Types for the flash macro command initiator: host operation codes and the
// controller state encoding.
package flash_phy_pkg;

  typedef enum logic [1:0] {
    OpRead    = 2'd0,
    OpProg    = 2'd1,
    OpPgErase = 2'd2,
    OpBkErase = 2'd3
  } flash_phy_op_e;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StRead,
    StWait,
    StError
  } phy_state_e;

  // Reads are the only pipelined operation; everything else is exclusive.
  function automatic logic op_is_read(input flash_phy_op_e op);
    return op == OpRead;
  endfunction

endpackage

// File: rtl/flash_phy_rsp_fifo.sv
// Small in-order response FIFO. Output comes straight from storage
// registers, so rdata/valid hold steady until the entry is popped.
module flash_phy_rsp_fifo #(
  parameter int Depth = 2,
  parameter int Width = 33,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_reg [Depth];
  logic [PtrW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]  cnt_reg;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_pop  = pop && (cnt_reg != '0);
  assign do_push = push && ((cnt_reg != CntW'(Depth)) || do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < Depth; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= wdata;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop) cnt_reg <= cnt_reg + CntW'(1);
      else if (do_pop && !do_push) cnt_reg <= cnt_reg - CntW'(1);
    end
  end

  assign valid = (cnt_reg != '0);
  assign rdata = mem_reg[rd_ptr_reg];
  assign count = cnt_reg;

endmodule

// File: rtl/flash_phy_host.sv
// Initiator for the flash macro command interface: accepts host requests,
// issues one-cycle command strobes, tracks pipelined reads, and returns
// in-order responses with timeout and spurious-ack error reporting.
module flash_phy_host
  import flash_ctrl_pkg::*, flash_phy_pkg::*;
#(
  parameter int PagesPerBank  = 256,
  parameter int WordsPerPage  = 256,
  parameter int DataWidth     = 32,
  parameter int MaxRdOut      = 2,
  parameter int TimeoutCycles = 200000,
  localparam int AddrW = $clog2(PagesPerBank) + $clog2(WordsPerPage)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 req_ready_o,
  input  flash_phy_op_e        req_op_i,
  input  logic [AddrW-1:0]     req_addr_i,
  input  flash_part_e          req_part_i,
  input  flash_prog_e          req_prog_type_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 err_o,
  output logic                 flash_rd_o,
  output logic                 flash_prog_o,
  output logic                 flash_pg_erase_o,
  output logic                 flash_bk_erase_o,
  output flash_prog_e          flash_prog_type_o,
  output logic [AddrW-1:0]     flash_addr_o,
  output flash_part_e          flash_part_o,
  output logic [DataWidth-1:0] flash_prog_data_o,
  input  logic                 flash_ack_i,
  input  logic [DataWidth-1:0] flash_rd_data_i,
  input  logic                 flash_init_busy_i,
  input  logic [ProgTypes-1:0] flash_prog_type_avail_i
);

  localparam int CntW   = $clog2(MaxRdOut + 1);
  localparam int TimerW = $clog2(TimeoutCycles + 1);

  phy_state_e        state_reg, state_next;
  logic [CntW-1:0]   rd_cnt_reg, rd_cnt_next;
  logic [TimerW-1:0] timer_reg, timer_next;
  logic              pend_err_reg;
  logic              err_reg, err_next;

  logic [CntW-1:0]    fifo_cnt;
  logic               fifo_push, fifo_pop, fifo_valid;
  logic [DataWidth:0] fifo_wdata, fifo_rdata;

  logic accept, is_read, rd_credit, prog_ok;
  logic issue_rd, issue_cmd, bad_type, ack_rd, ack_live, outstanding;

  // Acceptance, ack bookkeeping, timeout and next-state selection.
  always_comb begin
    state_next  = state_reg;
    rd_cnt_next = rd_cnt_reg;
    timer_next  = timer_reg;
    err_next    = err_reg;
    req_ready_o = 1'b0;
    fifo_push   = 1'b0;
    fifo_wdata  = '0;
    ack_rd      = 1'b0;

    is_read   = op_is_read(req_op_i);
    rd_credit = (int'(rd_cnt_reg) + int'(fifo_cnt)) < MaxRdOut;
    prog_ok   = (req_op_i != OpProg) || flash_prog_type_avail_i[req_prog_type_i];

    case (state_reg)
      StIdle:  req_ready_o = !pend_err_reg &&
                             (is_read ? rd_credit : (rd_cnt_reg == '0 && fifo_cnt == '0));
      StRead:  req_ready_o = is_read && rd_credit;
      default: req_ready_o = 1'b0;
    endcase

    accept      = req_i && req_ready_o;
    issue_rd    = accept && is_read;
    issue_cmd   = accept && !is_read && prog_ok;
    bad_type    = accept && !is_read && !prog_ok;
    ack_live    = flash_ack_i && (state_reg != StError);
    outstanding = (state_reg == StWait) || (state_reg != StError && rd_cnt_reg != '0);

    // Rejected program type: error response one cycle after acceptance.
    if (pend_err_reg) begin
      fifo_push  = 1'b1;
      fifo_wdata = {1'b1, {DataWidth{1'b0}}};
    end

    if (ack_live) begin
      if (state_reg == StWait) begin
        fifo_push  = 1'b1;
        fifo_wdata = '0;
      end else if (rd_cnt_reg != '0) begin
        fifo_push  = 1'b1;
        fifo_wdata = {1'b0, flash_rd_data_i};
        ack_rd     = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end

    if (issue_rd && !ack_rd) rd_cnt_next = rd_cnt_reg + CntW'(1);
    else if (ack_rd && !issue_rd) rd_cnt_next = rd_cnt_reg - CntW'(1);

    if (accept || ack_live) timer_next = '0;
    else if (outstanding) timer_next = timer_reg + TimerW'(1);
    else timer_next = '0;

    case (state_reg)
      StInit: if (!flash_init_busy_i) state_next = StIdle;
      StIdle: begin
        if (issue_rd) state_next = StRead;
        else if (issue_cmd) state_next = StWait;
      end
      StRead: if (rd_cnt_next == '0) state_next = StIdle;
      StWait: if (ack_live) state_next = StIdle;
      default: state_next = state_reg;
    endcase

    // The macro has gone quiet: report once and park until reset.
    if (outstanding && !ack_live && !accept && timer_reg == TimerW'(TimeoutCycles - 1)) begin
      fifo_push  = 1'b1;
      fifo_wdata = {1'b1, {DataWidth{1'b0}}};
      err_next   = 1'b1;
      state_next = StError;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= StInit;
      rd_cnt_reg   <= '0;
      timer_reg    <= '0;
      pend_err_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_cnt_reg   <= rd_cnt_next;
      timer_reg    <= timer_next;
      pend_err_reg <= bad_type;
      err_reg      <= err_next;
    end
  end

  // Registered command outputs; strobes last exactly one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flash_rd_o        <= 1'b0;
      flash_prog_o      <= 1'b0;
      flash_pg_erase_o  <= 1'b0;
      flash_bk_erase_o  <= 1'b0;
      flash_prog_type_o <= FlashProgNormal;
      flash_addr_o      <= '0;
      flash_part_o      <= FlashPartData;
      flash_prog_data_o <= '0;
    end else begin
      flash_rd_o       <= issue_rd;
      flash_prog_o     <= issue_cmd && (req_op_i == OpProg);
      flash_pg_erase_o <= issue_cmd && (req_op_i == OpPgErase);
      flash_bk_erase_o <= issue_cmd && (req_op_i == OpBkErase);
      if (accept) begin
        flash_prog_type_o <= req_prog_type_i;
        flash_addr_o      <= req_addr_i;
        flash_part_o      <= req_part_i;
        flash_prog_data_o <= req_wdata_i;
      end
    end
  end

  assign fifo_pop = rsp_valid_o && rsp_ready_i;

  flash_phy_rsp_fifo #(
    .Depth (MaxRdOut),
    .Width (DataWidth + 1)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .srst  (rst_i),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .valid (fifo_valid),
    .rdata (fifo_rdata),
    .count (fifo_cnt)
  );

  assign rsp_valid_o = fifo_valid;
  assign rsp_rdata_o = fifo_rdata[DataWidth-1:0];
  assign rsp_err_o   = fifo_rdata[DataWidth];
  assign err_o       = err_reg;

endmodule

// File: tb/tb_flash_phy_host.sv
// Directed bench for flash_phy_host driving an emulated flash macro with
// two-cycle ack latency, AND-programming and erase-to-ones semantics.
module tb_flash_phy_host;
  import flash_ctrl_pkg::*;
  import flash_phy_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req = 1'b0, req_ready;
  flash_phy_op_e req_op = OpRead;
  logic [AW-1:0] req_addr = '0;
  flash_part_e   req_part = FlashPartData;
  flash_prog_e   req_prog_type = FlashProgNormal;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err, err;
  logic [DW-1:0] rsp_rdata;
  logic          flash_rd, flash_prog, flash_pg_erase, flash_bk_erase;
  flash_prog_e   flash_prog_type;
  logic [AW-1:0] flash_addr;
  flash_part_e   flash_part;
  logic [DW-1:0] flash_prog_data;
  logic          flash_ack;
  logic [DW-1:0] flash_rd_data;
  logic          init_busy = 1'b1;
  logic [ProgTypes-1:0] avail = 2'b11;

  logic          model_ack = 1'b0, inject_ack = 1'b0, ack_block = 1'b0;
  logic [DW-1:0] model_rdata = '0;
  assign flash_ack     = model_ack | inject_ack;
  assign flash_rd_data = model_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_strobes = 0;
  int prog_strobes = 0;

  flash_phy_host #(.TimeoutCycles(100)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .req_ready_o(req_ready), .req_op_i(req_op), .req_addr_i(req_addr),
    .req_part_i(req_part), .req_prog_type_i(req_prog_type), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .err_o(err),
    .flash_rd_o(flash_rd), .flash_prog_o(flash_prog), .flash_pg_erase_o(flash_pg_erase),
    .flash_bk_erase_o(flash_bk_erase), .flash_prog_type_o(flash_prog_type),
    .flash_addr_o(flash_addr), .flash_part_o(flash_part), .flash_prog_data_o(flash_prog_data),
    .flash_ack_i(flash_ack), .flash_rd_data_i(flash_rd_data),
    .flash_init_busy_i(init_busy), .flash_prog_type_avail_i(avail)
  );

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Count strobes once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (flash_rd) rd_strobes++;
    if (flash_prog) prog_strobes++;
  end

  // Emulated macro memory: absent words read as erased.
  logic [DW-1:0] mem [int];
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 32'hFFFF_FFFF;
  endfunction

  typedef struct packed {
    logic          v;
    flash_phy_op_e op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mop_t;
  mop_t st1 = '0, st2 = '0;

  // Macro pipeline: a command strobed in cycle c is acked in cycle c+2.
  always @(negedge clk) begin
    mop_t cur;
    if (rst) begin
      st1 = '0; st2 = '0; model_ack = 1'b0; model_rdata = '0;
    end else begin
      model_ack = 1'b0;
      model_rdata = '0;
      if (st2.v && !ack_block) begin
        model_ack = 1'b1;
        case (st2.op)
          OpRead: model_rdata = mem_rd(st2.addr);
          OpProg: mem[int'(st2.addr)] = mem_rd(st2.addr) & st2.data;
          OpPgErase: begin
            for (int w = 0; w < 256; w++) begin
              if (mem.exists(int'({st2.addr[15:8], 8'h00}) + w))
                mem.delete(int'({st2.addr[15:8], 8'h00}) + w);
            end
          end
          default: mem.delete();
        endcase
      end
      st2 = st1;
      cur.v = flash_rd | flash_prog | flash_pg_erase | flash_bk_erase;
      cur.op = flash_prog ? OpProg : flash_pg_erase ? OpPgErase :
               flash_bk_erase ? OpBkErase : OpRead;
      cur.addr = flash_addr;
      cur.data = flash_prog_data;
      st1 = cur;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance with acc = accept cycle.
  task automatic send(input flash_phy_op_e op, input logic [AW-1:0] a, input flash_prog_e pt,
                      input logic [DW-1:0] d, output int acc);
    int n = 0;
    req = 1'b1; req_op = op; req_addr = a; req_prog_type = pt; req_wdata = d;
    #1;
    while (!req_ready && n < 300) begin
      @(negedge clk); #1; n++;
    end
    acc = cyc;
    if (!req_ready) chk("req_accept_wait", 32'(req_ready), 32'd1);
    @(negedge clk);
    req = 1'b0;
  endtask

  // Called at a negedge; waits for a response, captures it and pops it.
  task automatic get_rsp(output logic [DW-1:0] d, output logic e, output int c);
    int n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk); n++;
    end
    chk("rsp_wait", 32'(rsp_valid), 32'd1);
    d = rsp_rdata; e = rsp_err; c = cyc;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Simulation time guard.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, c, n0;
    logic [DW-1:0] d;
    logic e;
    logic [DW-1:0] bp_exp [4];

    // Reset and macro init
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_strobe", 32'(flash_rd), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("init_ready_low", 32'(req_ready), 32'd0);
    end
    init_busy = 1'b0;
    #1 chk("init_ready_same_cycle", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("init_ready_rise", 32'(req_ready), 32'd1);

    // Read of an erased word
    send(OpRead, 16'h0010, FlashProgNormal, '0, a);
    chk("rd_strobe", 32'(flash_rd), 32'd1);
    chk("rd_addr", 32'(flash_addr), 32'h0010);
    get_rsp(d, e, c);
    chk("rd_latency", 32'(c - a), 32'd4);
    chk("rd_data", d, 32'hFFFF_FFFF);
    chk("rd_err", 32'(e), 32'd0);

    // Program AND semantics and page erase
    n0 = prog_strobes;
    send(OpProg, 16'h0120, FlashProgNormal, 32'hA5A5_5A5A, a); get_rsp(d, e, c);
    chk("prog_rsp_data", d, 32'h0);
    chk("prog_rsp_err", 32'(e), 32'd0);
    send(OpProg, 16'h0020, FlashProgNormal, 32'h0000_FFFF, a); get_rsp(d, e, c);
    send(OpRead, 16'h0020, FlashProgNormal, '0, a); get_rsp(d, e, c);
    chk("prog1_read", d, 32'h0000_FFFF);
    send(OpProg, 16'h0020, FlashProgNormal, 32'hFFFF_0000, a); get_rsp(d, e, c);
    send(OpRead, 16'h0020, FlashProgNormal, '0, a); get_rsp(d, e, c);
    chk("prog_and_read", d, 32'h0000_0000);
    chk("prog_strobe_count", 32'(prog_strobes - n0), 32'd3);
    send(OpPgErase, 16'h0000, FlashProgNormal, '0, a); get_rsp(d, e, c);
    chk("pg_erase_err", 32'(e), 32'd0);
    send(OpRead, 16'h0020, FlashProgNormal, '0, a); get_rsp(d, e, c);
    chk("pg_erase_read", d, 32'hFFFF_FFFF);
    send(OpRead, 16'h0120, FlashProgNormal, '0, a); get_rsp(d, e, c);
    chk("pg_erase_other_page", d, 32'hA5A5_5A5A);
    send(OpProg, 16'h0011, FlashProgNormal, 32'h0F0F_0F0F, a); get_rsp(d, e, c);

    // Four back-to-back reads against a stalled response port
    bp_exp[0] = 32'hA5A5_5A5A; bp_exp[1] = 32'h0F0F_0F0F;
    bp_exp[2] = 32'hFFFF_FFFF; bp_exp[3] = 32'hA5A5_5A5A;
    n0 = rd_strobes;
    fork
      begin
        send(OpRead, 16'h0120, FlashProgNormal, '0, a2);
        send(OpRead, 16'h0011, FlashProgNormal, '0, a2);
        send(OpRead, 16'h0010, FlashProgNormal, '0, a2);
        send(OpRead, 16'h0120, FlashProgNormal, '0, a2);
      end
      begin
        repeat (8) @(negedge clk);
        #2;
        chk("bp_strobes", 32'(rd_strobes - n0), 32'd2);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          get_rsp(d, e, c);
          chk($sformatf("bp_rsp%0d_data", i), d, bp_exp[i]);
          chk($sformatf("bp_rsp%0d_err", i), 32'(e), 32'd0);
        end
      end
    join
    chk("bp_total_strobes", 32'(rd_strobes - n0), 32'd4);

    // Bank erase
    send(OpBkErase, 16'h0000, FlashProgNormal, '0, a); get_rsp(d, e, c);
    send(OpRead, 16'h0120, FlashProgNormal, '0, a); get_rsp(d, e, c);
    chk("bk_erase_read", d, 32'hFFFF_FFFF);

    // Unsupported program type
    avail = 2'b01;
    n0 = prog_strobes;
    send(OpProg, 16'h0030, FlashProgRepair, 32'h1234_5678, a);
    get_rsp(d, e, c);
    chk("badtype_latency", 32'(c - a), 32'd2);
    chk("badtype_err", 32'(e), 32'd1);
    chk("badtype_data", d, 32'h0);
    chk("badtype_no_strobe", 32'(prog_strobes - n0), 32'd0);
    chk("badtype_err_o", 32'(err), 32'd0);
    avail = 2'b11;
    send(OpRead, 16'h0030, FlashProgNormal, '0, a); get_rsp(d, e, c);
    chk("badtype_mem_untouched", d, 32'hFFFF_FFFF);

    // Spurious ack while idle
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    chk("spur_err_o", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    chk("spur_no_rsp", 32'(rsp_valid), 32'd0);
    chk("spur_ready", 32'(req_ready), 32'd1);

    // Reset clears the sticky error
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_err_o", 32'(err), 32'd0);
    chk("rst2_ready", 32'(req_ready), 32'd1);

    // Timeout on a program the macro never acknowledges
    ack_block = 1'b1;
    send(OpProg, 16'h0040, FlashProgNormal, 32'h0, a);
    get_rsp(d, e, c);
    chk("to_latency", 32'(c - a), 32'd101);
    chk("to_rsp_err", 32'(e), 32'd1);
    chk("to_rsp_data", d, 32'h0);
    chk("to_err_o", 32'(err), 32'd1);
    req = 1'b1; req_op = OpRead;
    for (int i = 0; i < 5; i++) begin
      #1 chk("to_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req = 1'b0;
    ack_block = 1'b0;
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("to_ack_dropped", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("to_rst_ready", 32'(req_ready), 32'd1);
    chk("to_rst_err_o", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
